// File: rtl/wcsl_multi.sv
// -----------------------------------------------------------------------------
// wcsl_multi -- multi-channel console switch register for the PDP-6 IO bus.
//
// Each of NCH 36-bit front-panel switch channels is synchronised (two flops)
// and debounced. A masked change on any channel raises that channel's flag.
// The flags, gated by the interrupt enable, drive a programmable PI level.
//
// Ports
//   clk                    system clock
//   reset                  asynchronous reset, active low
//   iobus_iob_poweron/
//   iobus_iob_reset        bus reset pulses (no device select needed)
//   iobus_datao_clear/set  DATAO pulses: load the change-detect mask
//   iobus_cono_clear/set   CONO pulses: pia, ien, chsel, flag clear (bit 32)
//   iobus_iob_fm_datai     read level: stable switches of the selected channel
//   iobus_iob_fm_status    read level: CONI status word
//   iobus_rdi_pulse        not used by this device
//   iobus_ios              device select code
//   iobus_iob_in           bus data in, bit 0 is MSB
//   iobus_pi_req           PI request lines 1..7
//   iobus_iob_out          bus data out (0 when not being read)
//   iobus_dr_split,
//   iobus_rdi_data         tied 0
//   sw                     switch levels, channel k in sw[36k+35:36k]
// -----------------------------------------------------------------------------
module wcsl_multi #(
   parameter logic [6:0] DEVSEL   = 7'b1110101,
   parameter int         NCH      = 2,
   parameter int         DEBOUNCE = 1000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               iobus_iob_poweron,
   input  logic               iobus_iob_reset,
   input  logic               iobus_datao_clear,
   input  logic               iobus_datao_set,
   input  logic               iobus_cono_clear,
   input  logic               iobus_cono_set,
   input  logic               iobus_iob_fm_datai,
   input  logic               iobus_iob_fm_status,
   input  logic               iobus_rdi_pulse,
   input  logic [3:9]         iobus_ios,
   input  logic [0:35]        iobus_iob_in,
   output logic [1:7]         iobus_pi_req,
   output logic [0:35]        iobus_iob_out,
   output logic               iobus_dr_split,
   output logic               iobus_rdi_data,
   input  logic [NCH*36-1:0]  sw
);

   localparam int             CW      = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0]  DEB_MAX = CW'(DEBOUNCE);

   // Per-channel input path state
   logic [35:0]    sync1_q  [NCH];
   logic [35:0]    sync2_q  [NCH];
   logic [35:0]    stable_q [NCH];
   logic [35:0]    stable_d [NCH];
   logic [CW-1:0]  cnt_q    [NCH];
   logic [CW-1:0]  cnt_d    [NCH];
   logic [NCH-1:0] flag_q, flag_d;
   logic [NCH-1:0] set_ev;

   // Programmed registers
   logic [2:0]     pia_q, pia_d;
   logic           ien_q, ien_d;
   logic [3:0]     chsel_q, chsel_d;
   logic [35:0]    mask_q, mask_d;
   logic [1:7]     pi_req_q, pi_req_d;

   logic           sel, bus_rst, flag_clr, any_flag;
   logic [35:0]    datai_word;
   logic [0:35]    coni_word;
   logic           unused_rdi;

   assign unused_rdi     = iobus_rdi_pulse;
   assign sel            = (iobus_ios == DEVSEL);
   assign bus_rst        = iobus_iob_reset | iobus_iob_poweron;
   assign flag_clr       = sel & iobus_cono_set & iobus_iob_in[32];
   assign any_flag       = |flag_q;
   assign iobus_dr_split = 1'b0;
   assign iobus_rdi_data = 1'b0;
   assign iobus_pi_req   = pi_req_q;

   // Debounce and change detection. sync1 != sync2 means sync2 is about to
   // move, so the counter restarts on the same edge sync2 takes a new value;
   // this gives the DEBOUNCE+3 cycle edge-to-stable latency.
   always_comb begin
      for (int k = 0; k < NCH; k++) begin
         stable_d[k] = stable_q[k];
         cnt_d[k]    = cnt_q[k];
         set_ev[k]   = 1'b0;
         if (sync1_q[k] != sync2_q[k]) begin
            cnt_d[k] = '0;
         end else if (sync2_q[k] != stable_q[k]) begin
            if (cnt_q[k] == DEB_MAX) begin
               stable_d[k] = sync2_q[k];
               cnt_d[k]    = '0;
               set_ev[k]   = |((stable_q[k] ^ sync2_q[k]) & mask_q);
            end else begin
               cnt_d[k] = cnt_q[k] + 1'b1;
            end
         end
      end
   end

   // Flags: a set event beats a CONO clear on the same cycle.
   always_comb begin
      flag_d = flag_q;
      for (int k = 0; k < NCH; k++) begin
         if (bus_rst)
            flag_d[k] = 1'b0;
         else if (set_ev[k])
            flag_d[k] = 1'b1;
         else if (flag_clr)
            flag_d[k] = 1'b0;
      end
   end

   // Programmed registers: clear pulse applied before set pulse.
   always_comb begin
      pia_d   = pia_q;
      ien_d   = ien_q;
      chsel_d = chsel_q;
      mask_d  = mask_q;
      if (bus_rst) begin
         pia_d   = '0;
         ien_d   = 1'b0;
         chsel_d = '0;
         mask_d  = '0;
      end else if (sel) begin
         if (iobus_datao_clear)
            mask_d = '0;
         if (iobus_datao_set)
            mask_d = mask_d | iobus_iob_in;
         if (iobus_cono_clear) begin
            pia_d   = '0;
            ien_d   = 1'b0;
            chsel_d = '0;
         end
         if (iobus_cono_set) begin
            pia_d   = pia_d | iobus_iob_in[33:35];
            ien_d   = ien_d | iobus_iob_in[31];
            chsel_d = chsel_d | iobus_iob_in[24:27];
         end
      end
   end

   always_comb begin
      pi_req_d = '0;
      for (int i = 1; i <= 7; i++)
         pi_req_d[i] = ien_q & any_flag & (pia_q == 3'(i));
   end

   // Read mux; a channel select beyond NCH reads as 0.
   always_comb begin
      datai_word = '0;
      for (int k = 0; k < NCH; k++)
         if (chsel_q == 4'(k))
            datai_word = stable_q[k];
   end

   always_comb begin
      coni_word = '0;
      for (int k = 0; k < NCH; k++)
         coni_word[k] = flag_q[k];
      coni_word[24:27] = chsel_q;
      coni_word[31]    = ien_q;
      coni_word[32]    = any_flag;
      coni_word[33:35] = pia_q;
   end

   always_comb begin
      iobus_iob_out = '0;
      if (sel & iobus_iob_fm_datai)
         iobus_iob_out = datai_word;
      else if (sel & iobus_iob_fm_status)
         iobus_iob_out = coni_word;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < NCH; k++) begin
            sync1_q[k]  <= '0;
            sync2_q[k]  <= '0;
            stable_q[k] <= '0;
            cnt_q[k]    <= '0;
         end
         flag_q   <= '0;
         pia_q    <= '0;
         ien_q    <= 1'b0;
         chsel_q  <= '0;
         mask_q   <= '0;
         pi_req_q <= '0;
      end else begin
         for (int k = 0; k < NCH; k++) begin
            sync1_q[k]  <= sw[36*k +: 36];
            sync2_q[k]  <= sync1_q[k];
            stable_q[k] <= stable_d[k];
            cnt_q[k]    <= cnt_d[k];
         end
         flag_q   <= flag_d;
         pia_q    <= pia_d;
         ien_q    <= ien_d;
         chsel_q  <= chsel_d;
         mask_q   <= mask_d;
         pi_req_q <= pi_req_d;
      end
   end

endmodule

// File: tb/tb_wcsl_multi.sv
module tb_wcsl_multi;

   localparam logic [6:0] DEVSEL = 7'b1110101;

   logic        clk;
   logic        reset;
   logic        iob_poweron, iob_reset;
   logic        datao_clear, datao_set, cono_clear, cono_set;
   logic        fm_datai, fm_status, rdi_pulse;
   logic [3:9]  ios;
   logic [0:35] iob_in;
   logic [1:7]  pi_req;
   logic [0:35] iob_out;
   logic        dr_split, rdi_data;
   logic [71:0] sw;

   int checks   = 0;
   int failures = 0;
   logic [35:0] v;

   wcsl_multi #(.DEVSEL(DEVSEL), .NCH(2), .DEBOUNCE(4)) dut (
      .clk                 (clk),
      .reset               (reset),
      .iobus_iob_poweron   (iob_poweron),
      .iobus_iob_reset     (iob_reset),
      .iobus_datao_clear   (datao_clear),
      .iobus_datao_set     (datao_set),
      .iobus_cono_clear    (cono_clear),
      .iobus_cono_set      (cono_set),
      .iobus_iob_fm_datai  (fm_datai),
      .iobus_iob_fm_status (fm_status),
      .iobus_rdi_pulse     (rdi_pulse),
      .iobus_ios           (ios),
      .iobus_iob_in        (iob_in),
      .iobus_pi_req        (pi_req),
      .iobus_iob_out       (iob_out),
      .iobus_dr_split      (dr_split),
      .iobus_rdi_data      (rdi_data),
      .sw                  (sw)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [35:0] got, input logic [35:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%012o exp=%012o", tag, got, exp);
      end
   endtask

   task automatic cono(input logic [35:0] val, input logic clr);
      @(negedge clk);
      iob_in     = val;
      cono_clear = clr;
      cono_set   = 1'b1;
      @(negedge clk);
      cono_clear = 1'b0;
      cono_set   = 1'b0;
      iob_in     = '0;
   endtask

   task automatic datao(input logic [35:0] val);
      @(negedge clk);
      iob_in      = val;
      datao_clear = 1'b1;
      datao_set   = 1'b1;
      @(negedge clk);
      datao_clear = 1'b0;
      datao_set   = 1'b0;
      iob_in      = '0;
   endtask

   task automatic rd_datai(output logic [35:0] val);
      @(negedge clk);
      fm_datai = 1'b1;
      #1 val = iob_out;
      fm_datai = 1'b0;
   endtask

   task automatic rd_coni(output logic [35:0] val);
      @(negedge clk);
      fm_status = 1'b1;
      #1 val = iob_out;
      fm_status = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      {iob_poweron, iob_reset, datao_clear, datao_set, cono_clear, cono_set} = '0;
      {fm_datai, fm_status, rdi_pulse} = '0;
      ios    = DEVSEL;
      iob_in = '0;
      sw     = {36'o123456701234, 36'o777777777777};

      // Reset state
      fm_datai = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_datai", iob_out, 36'o0);
      fm_datai  = 1'b0;
      fm_status = 1'b1;
      #1 check_val("rst_coni", iob_out, 36'o0);
      fm_status = 1'b0;
      check_val("rst_pi", {29'b0, pi_req}, 36'o0);
      check_val("tied0", {34'b0, dr_split, rdi_data}, 36'o0);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      rd_datai(v); check_val("post_rst_ch0", v, 36'o777777777777);

      // Debounce: glitch rejected, clean edge accepted after 7 edges
      sw[35:0] = 36'o777777777776;
      repeat (20) @(negedge clk);
      rd_datai(v); check_val("ch0_776", v, 36'o777777777776);
      @(negedge clk); sw[0] = 1'b1;
      repeat (3) @(negedge clk); sw[0] = 1'b0;
      repeat (15) @(negedge clk);
      rd_datai(v); check_val("glitch", v, 36'o777777777776);
      @(negedge clk);
      fm_datai = 1'b1;
      sw[0]    = 1'b1;
      repeat (6) @(posedge clk);
      #1 check_val("edge6_old", iob_out, 36'o777777777776);
      @(posedge clk);
      #1 check_val("edge7_new", iob_out, 36'o777777777777);
      fm_datai = 1'b0;

      // Channel select
      cono(36'o000000000400, 1'b1);
      rd_datai(v); check_val("chsel1", v, 36'o123456701234);
      cono(36'o000000001400, 1'b1);
      rd_datai(v); check_val("chsel3", v, 36'o0);
      rd_coni(v);  check_val("coni_chsel3", v, 36'o000000001400);

      // Unselected CONO ignored
      @(negedge clk); ios = 7'b0;
      cono(36'o000000000027, 1'b0);
      @(negedge clk); ios = DEVSEL;
      rd_coni(v);  check_val("unsel_cono", v, 36'o000000001400);

      // Mask and interrupt
      datao(36'o000000000001);
      cono(36'o000000000025, 1'b1);
      @(negedge clk); sw[35:0] = 36'o777777777775;
      repeat (12) @(negedge clk);
      rd_datai(v); check_val("bit34_silent", v, 36'o777777777775);
      rd_coni(v);  check_val("coni_noflag", v, 36'o000000000025);
      check_val("pi_noflag", {29'b0, pi_req}, 36'o0);
      @(negedge clk); sw[35:0] = 36'o777777777774;
      repeat (12) @(negedge clk);
      rd_coni(v);  check_val("coni_flag0", v, 36'o400000000035);
      check_val("pi5", {29'b0, pi_req}, 36'd4);
      @(negedge clk);
      fm_datai = 1'b1; fm_status = 1'b1;
      #1 check_val("datai_prio", iob_out, 36'o777777777774);
      fm_datai = 1'b0; fm_status = 1'b0;

      // Flag clear racing a new masked change on channel 1
      @(negedge clk); sw[36] = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      iob_in   = 36'o000000000010;
      cono_set = 1'b1;
      @(negedge clk);
      cono_set = 1'b0;
      iob_in   = '0;
      check_val("race_pi", {29'b0, pi_req}, 36'd4);
      rd_coni(v);  check_val("race_coni", v, 36'o200000000035);
      check_val("race_pi2", {29'b0, pi_req}, 36'd4);
      rd_datai(v); check_val("race_ch0", v, 36'o777777777774);

      // Bus reset during a pending debounce
      @(negedge clk); sw[35:0] = 36'o777777777775;
      repeat (3) @(posedge clk);
      @(negedge clk);
      ios       = 7'b0;
      iob_reset = 1'b1;
      @(negedge clk);
      iob_reset = 1'b0;
      ios       = DEVSEL;
      @(negedge clk);
      check_val("iorst_pi", {29'b0, pi_req}, 36'o0);
      rd_coni(v);  check_val("iorst_coni", v, 36'o0);
      repeat (12) @(negedge clk);
      rd_datai(v); check_val("iorst_ch0", v, 36'o777777777775);
      rd_coni(v);  check_val("iorst_noflag", v, 36'o0);
      check_val("iorst_pi2", {29'b0, pi_req}, 36'o0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
